// File: rtl/poly1305_seq_pkg.sv
// Shared widths, constants and FSM state encoding for the Poly1305 block sequencer.
package poly1305_seq_pkg;

    localparam int BLOCK_W = 128;
    localparam int KEY_W   = 256;
    localparam int TAG_W   = 128;
    localparam int BCNT_W  = 4;

    localparam logic [BCNT_W-1:0] FULL_BLOCK_BYTES_M1 = 4'd15;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        START,
        WAIT,
        TAG
    } seq_state_e;

endpackage

// File: rtl/poly1305_block_sequencer.sv
// Message-level controller for poly1305_serial_encoder: feeds one 128-bit block per
// encoder pass, holds it for the fixed encoder latency and returns the final tag.
module poly1305_block_sequencer
    import poly1305_seq_pkg::*;
#(
    parameter int BLOCK_LATENCY = 12
) (
    input  logic                clock,
    input  logic                clear_n,
    input  logic [KEY_W-1:0]    key,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [BLOCK_W-1:0]  s_data,
    input  logic                s_last,
    input  logic [BCNT_W-1:0]   s_bytes_minus_one,
    output logic                enc_clear,
    output logic                enc_start,
    output logic [KEY_W-1:0]    enc_key,
    output logic [BLOCK_W-1:0]  enc_round_input,
    output logic [BCNT_W-1:0]   enc_number_of_input_bytes_minus_one,
    input  logic [TAG_W-1:0]    enc_tag,
    output logic [TAG_W-1:0]    tag,
    output logic                tag_valid,
    input  logic                tag_ready,
    output logic                busy
);

    localparam int CNT_W = $clog2(BLOCK_LATENCY + 1);

    seq_state_e          state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic                first;
    logic                last_q;
    logic [KEY_W-1:0]    key_q;
    logic [BLOCK_W-1:0]  data_q;
    logic [BCNT_W-1:0]   bcnt_q;
    logic [TAG_W-1:0]    tag_q;
    logic                accept;
    logic                cnt_zero;

    assign accept   = s_valid && s_ready;
    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        enc_clear = 1'b0;
        enc_start = 1'b0;
        tag_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                s_ready = 1'b1;
                busy    = 1'b0;
                if (accept) state_nxt = first ? CLEAR : START;
            end
            CLEAR: begin
                enc_clear = 1'b1;
                state_nxt = START;
            end
            START: begin
                enc_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt_zero) state_nxt = last_q ? TAG : IDLE;
            end
            TAG: begin
                tag_valid = 1'b1;
                if (tag_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Block registers only move on an accepted word, so the encoder sees stable inputs
    // from its start pulse until the wait counter expires.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            first  <= 1'b1;
            last_q <= 1'b0;
            key_q  <= '0;
            data_q <= '0;
            bcnt_q <= '0;
            tag_q  <= '0;
            cnt    <= '0;
        end else begin
            if (accept) begin
                data_q <= s_data;
                last_q <= s_last;
                bcnt_q <= s_last ? s_bytes_minus_one : FULL_BLOCK_BYTES_M1;
                if (first) key_q <= key;
            end
            if (state == START) begin
                cnt   <= CNT_W'(BLOCK_LATENCY - 1);
                first <= 1'b0;
            end else if (state == WAIT && !cnt_zero) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (state == WAIT && cnt_zero && last_q) tag_q <= enc_tag;
            if (state == TAG && tag_ready) first <= 1'b1;
        end
    end

    assign enc_key                             = key_q;
    assign enc_round_input                     = data_q;
    assign enc_number_of_input_bytes_minus_one = bcnt_q;
    assign tag                                 = tag_q;

endmodule
